mem_arbiter: RTL and testbench

//  Owns the byte-wide RAM port and shares it between ICache refills and DCache refills/write-backs.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter_block_shifter.sv | 33 +++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the RAM-port arbiter: FSM states, grant identifiers and
// read/write direction codes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic GRANT_ICACHE = 1'b0;
    localparam logic GRANT_DCACHE = 1'b1;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side request/done signals and the byte-wide RAM port
// owned by mem_arbiter; slave is the arbiter, master is the cache/RAM side.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH  = 17,
    parameter int BLOCK_WIDTH = 4
);
    localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;
    localparam int TAG_WIDTH  = ADDR_WIDTH - BLOCK_WIDTH;

    // Handshake: a request is a level held until the matching done pulses for
    // one cycle; done is the only acknowledgement and blockData is valid with it.
    logic [7:0]              memIn;
    logic [ADDR_WIDTH-1:0]   memAddr;
    logic [7:0]              memOut;
    logic                    readWriteOut;
    logic                    icacheReq;
    logic [TAG_WIDTH-1:0]    icacheAddr;
    logic                    icacheDone;
    logic                    dcacheReq;
    logic                    dcacheReadWrite;
    logic [TAG_WIDTH-1:0]    dcacheAddr;
    logic [BLOCK_SIZE*8-1:0] dcacheDataIn;
    logic                    dcacheDone;
    logic [BLOCK_SIZE*8-1:0] blockData;
    logic                    busy;

    modport slave (
        input  memIn, icacheReq, icacheAddr, dcacheReq, dcacheReadWrite,
               dcacheAddr, dcacheDataIn,
        output memAddr, memOut, readWriteOut, icacheDone, dcacheDone,
               blockData, busy
    );

    modport master (
        output memIn, icacheReq, icacheAddr, dcacheReq, dcacheReadWrite,
               dcacheAddr, dcacheDataIn,
        input  memAddr, memOut, readWriteOut, icacheDone, dcacheDone,
               blockData, busy
    );

endinterface

// File: rtl/mem_arbiter_block_shifter.sv
// Block-sized byte register: whole-block load, byte-lane write by index and
// byte read by index; en low freezes the contents.
module block_shifter #(
    parameter int BLOCK_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           load,
    input  logic [(8<<BLOCK_WIDTH)-1:0]    load_data,
    input  logic                           wr,
    input  logic [BLOCK_WIDTH-1:0]         wr_idx,
    input  logic [7:0]                     wr_byte,
    input  logic [BLOCK_WIDTH-1:0]         rd_idx,
    output logic [7:0]                     rd_byte,
    output logic [(8<<BLOCK_WIDTH)-1:0]    block
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block <= '0;
        end else if (en) begin
            if (load) begin
                block <= load_data;
            end else if (wr) begin
                block[{wr_idx, 3'b000} +: 8] <= wr_byte;
            end
        end
    end

    assign rd_byte = block[{rd_idx, 3'b000} +: 8];

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM port between ICache refills and DCache refills/write-backs,
// one whole block per grant. Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic          clkIn,
    input  logic          resetIn,
    input  logic          readyIn,
    mem_arbiter_if.slave  bus,
    output state_t        state_dbg
);

    localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;
    localparam int TAG_WIDTH  = ADDR_WIDTH - BLOCK_WIDTH;
    localparam int CNT_W      = BLOCK_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_READ_LAST  = CNT_W'(BLOCK_SIZE);
    localparam logic [CNT_W-1:0] CNT_WRITE_LAST = CNT_W'(BLOCK_SIZE - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [TAG_WIDTH-1:0]   tag;
    logic                   grant;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [7:0]             mem_out;
    logic                   rw;
    logic                   icache_done;
    logic                   dcache_done;

    logic                   req_any;
    logic                   pick;
    logic [TAG_WIDTH-1:0]   pick_tag;
    logic                   pick_write;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CNT_W-1:0]       cnt_dec;
    logic [BLOCK_WIDTH-1:0] idx_next;
    logic [7:0]             rd_byte;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            last_grant <= GRANT_ICACHE;
        end else if (readyIn && state == ST_IDLE && req_any) begin
            last_grant <= pick;
        end
    end
`endif

    assign req_any = bus.icacheReq | bus.dcacheReq;

    always_comb begin
        pick = GRANT_ICACHE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (bus.dcacheReq && bus.icacheReq) begin
            pick = (last_grant == GRANT_ICACHE) ? GRANT_DCACHE : GRANT_ICACHE;
        end else if (bus.dcacheReq) begin
            pick = GRANT_DCACHE;
        end
`else
        if (bus.dcacheReq) begin
            pick = GRANT_DCACHE;
        end
`endif
    end

    assign pick_tag   = (pick == GRANT_DCACHE) ? bus.dcacheAddr : bus.icacheAddr;
    assign pick_write = (pick == GRANT_DCACHE) && (bus.dcacheReadWrite == RW_WRITE);
    assign cnt_inc    = cnt + 1'b1;
    assign cnt_dec    = cnt - 1'b1;
    assign idx_next   = cnt_inc[BLOCK_WIDTH-1:0];

    // One register serves both directions: refill bytes land in it, and a
    // write-back block is loaded into it at grant and read out byte by byte.
    block_shifter #(.BLOCK_WIDTH(BLOCK_WIDTH)) u_shifter (
        .clk       (clkIn),
        .rst_n     (resetIn),
        .en        (readyIn),
        .load      (state == ST_IDLE && req_any && pick_write),
        .load_data (bus.dcacheDataIn),
        .wr        (state == ST_READ && cnt != '0),
        .wr_idx    (cnt_dec[BLOCK_WIDTH-1:0]),
        .wr_byte   (bus.memIn),
        .rd_idx    (idx_next),
        .rd_byte   (rd_byte),
        .block     (bus.blockData)
    );

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            tag         <= '0;
            grant       <= GRANT_ICACHE;
            mem_addr    <= '0;
            mem_out     <= '0;
            rw          <= RW_READ;
            icache_done <= 1'b0;
            dcache_done <= 1'b0;
        end else if (readyIn) begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (req_any) begin
                        grant    <= pick;
                        tag      <= pick_tag;
                        mem_addr <= {pick_tag, {BLOCK_WIDTH{1'b0}}};
                        if (pick_write) begin
                            state   <= ST_WRITE;
                            rw      <= RW_WRITE;
                            mem_out <= bus.dcacheDataIn[7:0];
                        end else begin
                            state <= ST_READ;
                            rw    <= RW_READ;
                        end
                    end
                end
                // Read data trails the address by a cycle, so READ runs one
                // cycle past the last address to capture the final byte.
                ST_READ: begin
                    if (cnt == CNT_READ_LAST) begin
                        state       <= ST_DONE;
                        icache_done <= (grant == GRANT_ICACHE);
                        dcache_done <= (grant == GRANT_DCACHE);
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt < CNT_WRITE_LAST) begin
                            mem_addr <= {tag, idx_next};
                        end
                    end
                end
                ST_WRITE: begin
                    if (cnt == CNT_WRITE_LAST) begin
                        state       <= ST_DONE;
                        rw          <= RW_READ;
                        icache_done <= (grant == GRANT_ICACHE);
                        dcache_done <= (grant == GRANT_DCACHE);
                    end else begin
                        cnt      <= cnt_inc;
                        mem_addr <= {tag, idx_next};
                        mem_out  <= rd_byte;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    rw          <= RW_READ;
                    icache_done <= 1'b0;
                    dcache_done <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.memAddr      = mem_addr;
    assign bus.memOut       = mem_out;
    assign bus.readWriteOut = rw;
    assign bus.icacheDone   = icache_done;
    assign bus.dcacheDone   = dcache_done;
    assign bus.busy         = (state != ST_IDLE);
    assign state_dbg        = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, reset/tie/stall corner
// sequences and randomized traffic against a block-level memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 17;
    localparam int BW = 4;
    localparam int BS = 16;
    localparam int TW = AW - BW;
    localparam int DW = BS * 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct {
        bit            is_d;
        logic          dir;
        logic [TW-1:0] tag;
        logic [DW-1:0] wdata;
        int            stall_at;
        int            stall_len;
        int            exp_lat;
        logic [DW-1:0] exp_block;
    } txn_t;

    logic   clkIn = 1'b0;
    logic   resetIn = 1'b0;
    logic   readyIn = 1'b0;
    state_t state_dbg;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
        .clkIn     (clkIn),
        .resetIn   (resetIn),
        .readyIn   (readyIn),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clkIn = ~clkIn;

    int checks = 0;
    int errors = 0;
    logic model_last = GRANT_ICACHE;

    logic [7:0]    ram     [logic [AW-1:0]];
    logic [7:0]    ref_mem [logic [AW-1:0]];
    logic [AW+7:0] wr_q[$];
    logic [AW+7:0] exp_q[$];

    function automatic logic [7:0] pat(input logic [AW-1:0] a);
        if (a[AW-1:BW] == 13'h0123) return {4'h1, a[3:0]};
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [AW-1:0] a);
        return ram.exists(a) ? ram[a] : pat(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    // RAM device: one-cycle read latency, frozen like everything else by readyIn.
    always @(posedge clkIn) begin
        if (readyIn) begin
            bus.memIn <= ram_rd(bus.memAddr);
            if (bus.readWriteOut == RW_WRITE) begin
                ram[bus.memAddr] = bus.memOut;
                wr_q.push_back({bus.memAddr, bus.memOut});
            end
        end
    end

    function automatic logic model_pick(input bit ir, input bit dr);
        if (RR_EN && ir && dr) return (model_last == GRANT_ICACHE) ? GRANT_DCACHE : GRANT_ICACHE;
        return dr ? GRANT_DCACHE : GRANT_ICACHE;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        logic [AW-1:0] pa;
        logic [7:0]    po;
        logic [DW-1:0] pb;
        bit            hold;
        pa = bus.memAddr;
        po = bus.memOut;
        pb = bus.blockData;
        hold = !readyIn && resetIn;
        @(posedge clkIn);
        #1;
        if (hold && resetIn)
            check("stall_hold", {pa, po, pb}, {bus.memAddr, bus.memOut, bus.blockData});
    endtask

    task automatic raise(input txn_t t);
        if (t.is_d) begin
            bus.dcacheReq       = 1'b1;
            bus.dcacheReadWrite = t.dir;
            bus.dcacheAddr      = t.tag;
            bus.dcacheDataIn    = t.wdata;
        end else begin
            bus.icacheReq  = 1'b1;
            bus.icacheAddr = t.tag;
        end
    endtask

    task automatic wait_done(input int stall_pct, input int stall_at, input int stall_len,
                             output bit got_i, output bit got_d, output int total, output int active);
        int left;
        bit fired;
        left = 0;
        fired = 1'b0;
        total = 0;
        active = 0;
        while (!(bus.icacheDone || bus.dcacheDone) && total < 200) begin
            if (stall_at >= 0 && !fired && bus.busy && bus.memAddr[3:0] == stall_at[3:0]) begin
                fired = 1'b1;
                left = stall_len;
            end
            if (left > 0) begin
                readyIn = 1'b0;
                left--;
            end else begin
                readyIn = ($urandom_range(0, 99) >= stall_pct);
            end
            if (readyIn) active++;
            step();
            total++;
        end
        got_i = bus.icacheDone;
        got_d = bus.dcacheDone;
        if (!(got_i || got_d)) check("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic finish_done(input int stall_pct);
        bit was_i;
        bit was_d;
        bit held;
        int n;
        was_i = bus.icacheDone;
        was_d = bus.dcacheDone;
        n = 0;
        if (was_i) bus.icacheReq = 1'b0;
        if (was_d) bus.dcacheReq = 1'b0;
        do begin
            readyIn = ($urandom_range(0, 99) >= stall_pct);
            held = !readyIn;
            step();
            n++;
            if (held) check("done_held", {bus.icacheDone, bus.dcacheDone}, {was_i, was_d});
        end while (held && n < 20);
        check("done_one_cycle", {bus.icacheDone, bus.dcacheDone}, 2'b00);
        check("idle_after_done", bus.busy, 1'b0);
    endtask

    // The transaction t must be the next one granted; its outcome comes from ref_mem.
    task automatic serve(input txn_t t, input int stall_pct, input bit use_tbl);
        logic [DW-1:0] exp_blk;
        logic [AW-1:0] a;
        logic [BW-1:0] li;
        int base, tot, act, mism;
        bit gi, gd;
        base = wr_q.size();
        exp_q.delete();
        exp_blk = '0;
        for (int i = 0; i < BS; i++) begin
            li = BW'(i);
            a = {t.tag, li};
            if (t.dir == RW_WRITE) begin
                exp_q.push_back({a, t.wdata[8*i +: 8]});
                ref_mem[a] = t.wdata[8*i +: 8];
            end else begin
                exp_blk[8*i +: 8] = ref_rd(a);
            end
        end
        if (use_tbl) exp_blk = t.exp_block;
        model_last = t.is_d ? GRANT_DCACHE : GRANT_ICACHE;
        wait_done(stall_pct, t.stall_at, t.stall_len, gi, gd, tot, act);
        check("grant_owner", {gi, gd}, t.is_d ? 2'b01 : 2'b10);
        if (t.dir == RW_READ) begin
            check("block_data", bus.blockData, exp_blk);
        end else begin
            mism = 0;
            for (int i = 0; i < BS; i++)
                if (base + i >= wr_q.size() || wr_q[base+i] !== exp_q[i]) mism++;
            check("write_count", wr_q.size() - base, BS);
            check("write_sequence", mism, 0);
        end
        if (stall_pct == 0) check("latency_cycles", tot, t.exp_lat);
        else check("latency_active", act, (t.dir == RW_READ) ? BS + 2 : BS + 1);
        finish_done(stall_pct);
    endtask

    function automatic txn_t rand_txn(input bit is_d);
        txn_t t;
        int   sel;
        t.is_d = is_d;
        t.dir = is_d ? logic'($urandom_range(0, 1)) : RW_READ;
        sel = $urandom_range(0, 3);
        t.tag = (sel == 0) ? 13'h0040 : (sel == 1) ? 13'h0050 : (sel == 2) ? 13'h0123
                           : TW'($urandom_range(0, 8191));
        t.wdata = {$urandom, $urandom, $urandom, $urandom};
        t.stall_at = -1;
        t.stall_len = 0;
        t.exp_lat = 0;
        t.exp_block = '0;
        return t;
    endfunction

    txn_t tbl[6];
    txn_t t_d, t_i, ta, tb;
    logic w;
    int   n;

    initial begin
        tbl[0] = '{0, RW_READ,  13'h0123, '0, -1, 0, 18, 128'h1F1E1D1C1B1A19181716151413121110};
        tbl[1] = '{1, RW_WRITE, 13'h0040, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, -1, 0, 17, '0};
        tbl[2] = '{1, RW_READ,  13'h0040, '0, -1, 0, 18, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0};
        tbl[3] = '{1, RW_WRITE, 13'h0050, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 7, 3, 20, '0};
        tbl[4] = '{1, RW_READ,  13'h0050, '0, 5, 3, 21, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0};
        tbl[5] = '{0, RW_READ,  13'h0040, '0, -1, 0, 18, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0};

        bus.icacheReq = 1'b0;
        bus.icacheAddr = '0;
        bus.dcacheReq = 1'b0;
        bus.dcacheReadWrite = RW_READ;
        bus.dcacheAddr = '0;
        bus.dcacheDataIn = '0;

        #12;
        check("rst_mem_addr", bus.memAddr, '0);
        check("rst_mem_out", bus.memOut, '0);
        check("rst_rw", bus.readWriteOut, 1'b1);
        check("rst_icache_done", bus.icacheDone, 1'b0);
        check("rst_dcache_done", bus.dcacheDone, 1'b0);
        check("rst_block_data", bus.blockData, '0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_state", state_dbg, ST_IDLE);
        @(posedge clkIn);
        #1;
        resetIn = 1'b1;
        readyIn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            raise(tbl[i]);
            serve(tbl[i], 0, 1'b1);
        end

        // Reset in the middle of a refill, then the same request runs afresh.
        readyIn = 1'b1;
        raise(tbl[0]);
        n = 0;
        while (!(bus.busy && bus.memAddr[3:0] == 4'h5) && n < 40) begin
            step();
            n++;
        end
        check("midrst_reached_byte5", bus.memAddr, 17'h01235);
        #2 resetIn = 1'b0;
        #1;
        check("midrst_mem_addr", bus.memAddr, '0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_rw", bus.readWriteOut, 1'b1);
        check("midrst_block_data", bus.blockData, '0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("midrst_no_done", {bus.icacheDone, bus.dcacheDone}, 2'b00);
        end
        resetIn = 1'b1;
        model_last = GRANT_ICACHE;
        check("midrst_idle", state_dbg, ST_IDLE);
        serve(tbl[0], 0, 1'b1);

        // Back-to-back ties with both requests held, then DCache withdraws.
        t_d = tbl[2];
        t_i = tbl[0];
        raise(t_d);
        raise(t_i);
        for (int g = 0; g < 4; g++) begin
            w = model_pick(1'b1, 1'b1);
            if (w == GRANT_DCACHE) begin
                serve(t_d, 0, 1'b1);
                raise(t_d);
            end else begin
                serve(t_i, 0, 1'b1);
                raise(t_i);
            end
        end
        bus.dcacheReq = 1'b0;
        serve(t_i, 0, 1'b1);

        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = $urandom_range(0, 3);
            ta = rand_txn(1'b1);
            tb = rand_txn(1'b0);
            if (kind == 0) begin
                raise(tb);
                serve(tb, 15, 1'b0);
            end else if (kind < 3) begin
                ta.dir = (kind == 1) ? RW_READ : RW_WRITE;
                raise(ta);
                serve(ta, 15, 1'b0);
            end else begin
                raise(ta);
                raise(tb);
                w = model_pick(1'b1, 1'b1);
                if (w == GRANT_DCACHE) begin
                    serve(ta, 15, 1'b0);
                    serve(tb, 15, 1'b0);
                end else begin
                    serve(tb, 15, 1'b0);
                    serve(ta, 15, 1'b0);
                end
            end
        end

        readyIn = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
